// File: rtl/i2c_slave_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_cfg_ctrl
// Description : Configuration and recovery controller for the I2C-slave to
//               AXI-lite bridge. Applies software-requested enable/address
//               only while the I2C bus is idle, watches bridge busy for hung
//               transfers and forces the bridge back to idle by pulsing enable
//               low. Also counts addressed transfers and timeout events.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   cfg_enable          in   requested bridge enable
//   cfg_device_address  in   requested 7-bit slave address
//   cfg_valid           in   config request valid
//   cfg_ready           out  config request accepted when valid & ready
//   timeout_limit       in   busy-cycle limit, 0 disables the timeout
//   busy                in   bridge busy
//   bus_addressed       in   bridge currently addressed
//   bus_active          in   bridge sees I2C bus activity
//   enable              out  bridge enable
//   device_address      out  bridge slave address
//   recovering          out  high while the bridge is being forced idle
//   xfer_count          out  rising edges of bus_addressed, wraps
//   timeout_count       out  timeouts taken, saturates at 255
// ============================================================================
module i2c_slave_cfg_ctrl #(
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int RECOVER_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_enable,
  input  logic [6:0]               cfg_device_address,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic                     busy,
  input  logic                     bus_addressed,
  input  logic                     bus_active,
  output logic                     enable,
  output logic [6:0]               device_address,
  output logic                     recovering,
  output logic [CNT_WIDTH-1:0]     xfer_count,
  output logic [7:0]               timeout_count
);

  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [REC_W-1:0]         REC_LAST = REC_W'(RECOVER_CYCLES - 1);
  localparam logic [REC_W-1:0]         REC_ONE  = REC_W'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE   = TIMEOUT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     XF_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_RECOVER   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                     pend_enable;
  logic [6:0]               pend_address;
  logic [TIMEOUT_WIDTH-1:0] busy_cnt;
  logic [REC_W-1:0]         rec_cnt;
  logic                     addressed_d;

  logic idle;
  logic timeout_hit;
  logic rec_done;
  logic do_accept;
  logic do_apply;
  logic do_enter_rec;
  logic do_leave_rec;

  assign idle      = !busy && !bus_active;
  assign cfg_ready = (state == ST_RUN);
  assign rec_done  = (rec_cnt == REC_LAST);

  // busy_cnt holds the number of busy cycles already seen, so comparing it
  // against limit-1 while busy is still high fires on exactly the
  // timeout_limit-th consecutive busy cycle.
  assign timeout_hit = (timeout_limit != '0) && busy &&
                       (busy_cnt == (timeout_limit - TO_ONE));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    do_accept    = 1'b0;
    do_apply     = 1'b0;
    do_enter_rec = 1'b0;
    do_leave_rec = 1'b0;
    case (state)
      ST_RUN: begin
        // The handshake completes even when a timeout fires in the same
        // cycle; the timeout only takes priority for the state transition.
        do_accept = cfg_valid;
        if (timeout_hit) begin
          do_enter_rec = 1'b1;
          state_next   = ST_RECOVER;
        end else if (cfg_valid) begin
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // idle requires busy=0, so it can never coincide with a timeout.
        if (timeout_hit) begin
          do_enter_rec = 1'b1;
          state_next   = ST_RECOVER;
        end else if (idle) begin
          do_apply   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RECOVER: begin
        if (rec_done) begin
          do_leave_rec = 1'b1;
          state_next   = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending configuration (last accepted request)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_enable  <= 1'b0;
      pend_address <= 7'd0;
    end else if (do_accept) begin
      pend_enable  <= cfg_enable;
      pend_address <= cfg_device_address;
    end
  end

  // --------------------------------------------------------------------------
  // Bridge-facing outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable         <= 1'b0;
      device_address <= 7'd0;
      recovering     <= 1'b0;
    end else begin
      if (do_enter_rec) begin
        enable     <= 1'b0;
        recovering <= 1'b1;
      end else if (do_apply || do_leave_rec) begin
        enable         <= pend_enable;
        device_address <= pend_address;
        recovering     <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Recovery length counter: runs 0..RECOVER_CYCLES-1 while in RECOVER
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_cnt <= '0;
    end else if (do_enter_rec) begin
      rec_cnt <= '0;
    end else if ((state == ST_RECOVER) && !rec_done) begin
      rec_cnt <= rec_cnt + REC_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Busy watchdog counter: only counts while the bridge is enabled, held at
  // zero throughout recovery so the next run starts from a clean slate.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (!busy || do_enter_rec || (state == ST_RECOVER)) begin
      busy_cnt <= '0;
    end else if (enable && (busy_cnt != '1)) begin
      busy_cnt <= busy_cnt + TO_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count <= 8'd0;
    end else if (do_enter_rec && (timeout_count != 8'hFF)) begin
      timeout_count <= timeout_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addressed_d <= 1'b0;
      xfer_count  <= '0;
    end else begin
      addressed_d <= bus_addressed;
      if (bus_addressed && !addressed_d) begin
        xfer_count <= xfer_count + XF_ONE;
      end
    end
  end

endmodule
`default_nettype wire
